// File: rtl/prio_encoder_pipe_if.sv
// ---------------------------------------------------------------------------
// prio_encoder_pipe_if
// Handshake bundle for prio_encoder_pipe.
//   N          : number of request lines (2..64)
//   W          : encoded index width, derived from N
//   in_valid   : producer presents req this cycle
//   in_ready   : encoder accepts req this cycle
//   req        : request vector, bit i = request i active
//   out_valid  : out_idx/out_hit hold a result
//   out_ready  : consumer takes the result this cycle
//   out_idx    : granted request index
//   out_hit    : at least one request bit was set
// The N used here must match the N of the encoder it is bound to.
// ---------------------------------------------------------------------------
interface prio_encoder_pipe_if #(
  parameter int N = 8
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_hit;

  // master: the side that feeds requests and consumes results
  modport master (
    output in_valid, req, out_ready,
    input  in_ready, out_valid, out_idx, out_hit
  );

  // slave: the encoder itself
  modport slave (
    input  in_valid, req, out_ready,
    output in_ready, out_valid, out_idx, out_hit
  );
endinterface

// File: rtl/prio_encoder_pipe.sv
// ---------------------------------------------------------------------------
// prio_encoder_pipe
// Priority encoder with one registered output stage and valid/ready flow
// control on both sides.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : prio_encoder_pipe_if.slave (in_valid/in_ready/req in,
//          out_valid/out_ready/out_idx/out_hit out)
// Configuration macro: PRIO_ENCODER_RR_EN
//   undefined : fixed priority, highest set index wins
//   defined   : round-robin; a pointer ptr marks the current highest-priority
//               position and moves just below each granted index
// ---------------------------------------------------------------------------
module prio_encoder_pipe #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  prio_encoder_pipe_if.slave   bus
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q,   out_idx_d;
  logic         out_hit_q,   out_hit_d;

  logic         in_xfer;
  logic         req_hit;
  logic [W-1:0] grant;

  // The output register can take a new value whenever it is empty or being
  // drained in the same cycle.
  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign in_xfer      = bus.in_valid & bus.in_ready;
  assign req_hit      = |bus.req;

`ifdef PRIO_ENCODER_RR_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Search downward from ptr, wrapping from 0 to N-1; first set bit wins.
  always_comb begin : rr_search
    int  k;
    logic found;
    grant = '0;
    found = 1'b0;
    k     = 0;
    for (int s = 0; s < N; s++) begin
      k = int'(ptr_q) - s;
      if (k < 0) k = k + N;
      if (!found && bus.req[k]) begin
        grant = W'(k);
        found = 1'b1;
      end
    end
  end

  // The granted index drops to lowest priority for the next search. An
  // all-zero vector leaves the pointer alone.
  always_comb begin
    ptr_d = ptr_q;
    if (in_xfer && req_hit) begin
      ptr_d = (grant == '0) ? W'(N - 1) : grant - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i]) grant = W'(i);
    end
  end
`endif

  // A new input always reloads the stage, even while the old result is being
  // taken; a drain with no new input only clears valid and keeps the data.
  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_hit_d   = out_hit_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_idx_d   = grant;
      out_hit_d   = req_hit;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_hit_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_hit_q   <= out_hit_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_hit   = out_hit_q;
endmodule
